// File: rtl/belt_warn_pkg.sv
// Shared constants for the seat-belt warning annunciator: FSM encoding,
// default timing parameters and a counter-width helper.
package belt_warn_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WARN_BUZZ  = 2'd1;
    localparam logic [1:0] ST_WARN_QUIET = 2'd2;

    localparam int DEF_TICK_DIV    = 10;
    localparam int DEF_BLINK_TICKS = 5;
    localparam int DEF_BUZZ_TICKS  = 30;
    localparam int DEF_DEBOUNCE    = 4;

    // Bits needed to hold 0..max_val, never fewer than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/belt_warn_annunciator_debounce.sv
// Single-bit debouncer: the output follows the raw line only after it has
// disagreed for DEBOUNCE consecutive clock edges.
module belt_debounce
    import belt_warn_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic raw,
    output logic deb
);

    localparam int CW = cnt_width(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (raw != deb) begin
            // The edge that would bring the count to DEBOUNCE flips the output.
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                deb <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/belt_warn_annunciator.sv
// Seat-belt warning annunciator: debounced K/P/S sensors drive a blinking
// lamp, a time-limited buzzer and an activity flag.
module belt_warn_annunciator
    import belt_warn_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int BLINK_TICKS = DEF_BLINK_TICKS,
    parameter int BUZZ_TICKS  = DEF_BUZZ_TICKS,
    parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic K_s,
    input  logic P_s,
    input  logic S_s,
    output logic Lamp_s,
    output logic Buzz_s,
    output logic Active_s
);

    // state      | meaning
    // IDLE       | no warning, all outputs off, timebase stopped
    // WARN_BUZZ  | warning active, lamp blinking, buzzer on
    // WARN_QUIET | warning active, lamp blinking, buzzer done until re-armed

    localparam int PW = cnt_width(TICK_DIV - 1);
    localparam int LW = cnt_width(BLINK_TICKS - 1);
    localparam int BW = cnt_width(BUZZ_TICKS - 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] BLINK_LAST = LW'(BLINK_TICKS - 1);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_TICKS - 1);

    logic          k_d, p_d, s_d;
    logic          warn;
    logic          tick;
    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [LW-1:0] blink_cnt;
    logic [BW-1:0] buzz_cnt;
    logic          lamp_q, buzz_q;

    belt_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_k (.Clk(Clk), .Rst_n(Rst_n), .raw(K_s), .deb(k_d));
    belt_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_p (.Clk(Clk), .Rst_n(Rst_n), .raw(P_s), .deb(p_d));
    belt_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_s (.Clk(Clk), .Rst_n(Rst_n), .raw(S_s), .deb(s_d));

    assign warn = k_d & p_d & ~s_d;
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            presc     <= '0;
            blink_cnt <= '0;
            buzz_cnt  <= '0;
            lamp_q    <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (warn) begin
                        state     <= ST_WARN_BUZZ;
                        presc     <= '0;
                        blink_cnt <= '0;
                        buzz_cnt  <= '0;
                        lamp_q    <= 1'b1;
                        buzz_q    <= 1'b1;
                    end
                end
                ST_WARN_BUZZ, ST_WARN_QUIET: begin
                    // Loss of the warning condition overrides any timer event.
                    if (!warn) begin
                        state     <= ST_IDLE;
                        presc     <= '0;
                        blink_cnt <= '0;
                        buzz_cnt  <= '0;
                        lamp_q    <= 1'b0;
                        buzz_q    <= 1'b0;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                lamp_q    <= ~lamp_q;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                            if (state == ST_WARN_BUZZ) begin
                                if (buzz_cnt == BUZZ_LAST) begin
                                    state  <= ST_WARN_QUIET;
                                    buzz_q <= 1'b0;
                                end else begin
                                    buzz_cnt <= buzz_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    lamp_q <= 1'b0;
                    buzz_q <= 1'b0;
                end
            endcase
        end
    end

    assign Lamp_s   = lamp_q;
    assign Buzz_s   = buzz_q;
    assign Active_s = (state != ST_IDLE);

endmodule

// File: tb/tb_belt_warn_annunciator.sv
// Directed bench for belt_warn_annunciator at default parameters.
module tb_belt_warn_annunciator;

    logic clk = 1'b0;
    logic rst_n, k, p, s;
    logic lamp, buzz, active;

    int errors = 0;
    int checks = 0;
    int n = 0;

    belt_warn_annunciator dut (
        .Clk(clk), .Rst_n(rst_n), .K_s(k), .P_s(p), .S_s(s),
        .Lamp_s(lamp), .Buzz_s(buzz), .Active_s(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic l, input logic b, input logic a);
        chk({tag, "_lamp"}, 32'(lamp), 32'(l));
        chk({tag, "_buzz"}, 32'(buzz), 32'(b));
        chk({tag, "_active"}, 32'(active), 32'(a));
    endtask

    // n = edges since warning entry; lamp half-period 50, buzzer 300 cycles.
    task automatic step_model(input string tag);
        step();
        n++;
        chk_all(tag, ((n / 50) % 2) == 0, n < 300, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; k = 1'b1; p = 1'b1; s = 1'b0;
        repeat (3) step();
        chk_all("rst", 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rel_idle", 32'(active), 32'd0);
        end
        step();
        chk_all("rel_entry", 1'b1, 1'b1, 1'b1);
        n = 0;

        repeat (400) step_model("full");

        s = 1'b1;
        repeat (3) step_model("g3");
        s = 1'b0;
        repeat (20) step_model("g3_after");

        s = 1'b1;
        repeat (4) step_model("g4");
        s = 1'b0;
        step();
        chk_all("g4_low", 1'b0, 1'b0, 1'b0);
        for (int i = 6; i <= 8; i++) begin
            step();
            chk("g4_idle", 32'(active), 32'd0);
        end
        step();
        chk_all("g4_reentry", 1'b1, 1'b1, 1'b1);
        n = 0;

        repeat (100) step_model("pre_koff");
        k = 1'b0;
        repeat (4) step_model("koff_wait");
        step();
        chk_all("koff_low", 1'b0, 1'b0, 1'b0);

        k = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("kon_idle", 32'(active), 32'd0);
        end
        step();
        chk_all("kon_entry", 1'b1, 1'b1, 1'b1);
        n = 0;
        repeat (320) step_model("to_quiet");

        s = 1'b1;
        repeat (4) step_model("rearm_s");
        step();
        chk_all("rearm_low", 1'b0, 1'b0, 1'b0);
        for (int i = 6; i <= 10; i++) begin
            step();
            chk("rearm_idle_s1", 32'(active), 32'd0);
        end
        s = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            step();
            chk("rearm_idle_s0", 32'(active), 32'd0);
        end
        step();
        chk_all("rearm_entry", 1'b1, 1'b1, 1'b1);
        n = 0;
        repeat (310) step_model("rearm");

        // Lamp is on here (n=310); reset lands mid-cycle, well before the next edge.
        chk("pre_async_lamp", 32'(lamp), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("async_hold", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("post_rst_idle", 32'(active), 32'd0);
        end
        step();
        chk_all("post_rst_entry", 1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
